// File: rtl/colour_pkg.sv
// Shared pixel and maths types for the render pipeline.
package colour;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } colour_t;

    localparam int FP_FRAC_BITS = 16;

    // Signed 16.16 fixed point used by the ray stage.
    typedef logic signed [31:0] fixed_point_t;

    typedef struct packed {
        fixed_point_t x;
        fixed_point_t y;
        fixed_point_t z;
    } vector_t;

    function automatic fixed_point_t fp_from_int(input logic signed [15:0] v);
        return fixed_point_t'(v) <<< FP_FRAC_BITS;
    endfunction

endpackage

// File: rtl/vga_sync_timing_counter.sv
// Raster h/v counters and raw timing flags, shareable with the ray stage.
module timing_counter #(
    parameter int hWidth      = 1024,
    parameter int hFrontPorch = 24,
    parameter int hSyncWidth  = 136,
    parameter int hBackPorch  = 160,
    parameter int vWidth      = 768,
    parameter int vFrontPorch = 9,
    parameter int vSyncWidth  = 6,
    parameter int vBackPorch  = 23
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic active_o,
    output logic hs_o,
    output logic vs_o,
    output logic fs_o
);
    localparam int H_TOTAL = hWidth + hFrontPorch + hSyncWidth + hBackPorch;
    localparam int V_TOTAL = vWidth + vFrontPorch + vSyncWidth + vBackPorch;
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    localparam logic [HCW-1:0] H_LAST = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT  = HCW'(hWidth);
    localparam logic [HCW-1:0] H_SS   = HCW'(hWidth + hFrontPorch);
    localparam logic [HCW-1:0] H_SE   = HCW'(hWidth + hFrontPorch + hSyncWidth);
    localparam logic [VCW-1:0] V_LAST = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_ACT  = VCW'(vWidth);
    localparam logic [VCW-1:0] V_SS   = VCW'(vWidth + vFrontPorch);
    localparam logic [VCW-1:0] V_SE   = VCW'(vWidth + vFrontPorch + vSyncWidth);

    logic [HCW-1:0] hcount_q, hcount_d;
    logic [VCW-1:0] vcount_q, vcount_d;

    // vCount only moves on the hCount wrap, so both wrap on one edge.
    always_comb begin
        hcount_d = hcount_q + 1'b1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    assign active_o = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    assign hs_o     = (hcount_q >= H_SS) && (hcount_q < H_SE);
    assign vs_o     = (vcount_q >= V_SS) && (vcount_q < V_SE);
    assign fs_o     = (hcount_q == '0) && (vcount_q == '0);

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: delays raw timing flags to match the shading pipeline.
module vga_sync
    import colour::*;
#(
    parameter int   hWidth       = 1024,
    parameter int   hFrontPorch  = 24,
    parameter int   hSyncWidth   = 136,
    parameter int   hBackPorch   = 160,
    parameter int   vWidth       = 768,
    parameter int   vFrontPorch  = 9,
    parameter int   vSyncWidth   = 6,
    parameter int   vBackPorch   = 23,
    parameter int   PIPE_LATENCY = 4,
    parameter logic HSYNC_POL    = 1'b0,
    parameter logic VSYNC_POL    = 1'b0
) (
    input  logic    pixel_clk,
    input  logic    rst,
    input  colour_t colour_in,
    output logic    hsync,
    output logic    vsync,
    output logic    blank,
    output colour_t colour_out,
    output logic    frame_start
);
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic fs;
    } flags_t;

    logic   raw_active, raw_hs, raw_vs, raw_fs;
    flags_t raw;
    flags_t aligned;

    timing_counter #(
        .hWidth      (hWidth),
        .hFrontPorch (hFrontPorch),
        .hSyncWidth  (hSyncWidth),
        .hBackPorch  (hBackPorch),
        .vWidth      (vWidth),
        .vFrontPorch (vFrontPorch),
        .vSyncWidth  (vSyncWidth),
        .vBackPorch  (vBackPorch)
    ) u_timing (
        .clk_i    (pixel_clk),
        .rst_i    (rst),
        .active_o (raw_active),
        .hs_o     (raw_hs),
        .vs_o     (raw_vs),
        .fs_o     (raw_fs)
    );

    assign raw = '{active: raw_active, hs: raw_hs, vs: raw_vs, fs: raw_fs};

    // Reset clears every stage so no pre-reset flags survive a restart.
    generate
        if (PIPE_LATENCY == 0) begin : g_no_delay
            assign aligned = raw;
        end else begin : g_delay
            flags_t dly_q [PIPE_LATENCY];

            always_ff @(posedge pixel_clk) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_LATENCY; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q[0] <= raw;
                    for (int i = 1; i < PIPE_LATENCY; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign aligned = dly_q[PIPE_LATENCY-1];
        end
    endgenerate

    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;
    logic    blank_q, blank_d;
    logic    fs_q, fs_d;
    colour_t colour_q, colour_d;

    always_comb begin
        hsync_d  = aligned.hs ? HSYNC_POL : ~HSYNC_POL;
        vsync_d  = aligned.vs ? VSYNC_POL : ~VSYNC_POL;
        blank_d  = ~aligned.active;
        fs_d     = aligned.fs;
        colour_d = aligned.active ? colour_in : '0;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            hsync_q  <= ~HSYNC_POL;
            vsync_q  <= ~VSYNC_POL;
            blank_q  <= 1'b1;
            fs_q     <= 1'b0;
            colour_q <= '0;
        end else begin
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
            fs_q     <= fs_d;
            colour_q <= colour_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;
    assign colour_out  = colour_q;

endmodule
